dff_segment_for_input: RTL and testbench

Input-side deserializer for the 64-point FFT datapath. It collects a serial stream of complex samples into 8-sample frames and presents each frame as one 8-lane parallel word to the first butterfly stage. It mirrors the output segment, which turns parallel lanes back into a serial stream. A double-buffered output bank lets collection of frame n+1 overlap consumption of frame n.

---
 rtl/fft_seg_pkg.sv | 16 +
 rtl/dff_hold_async_low_reset.sv | 22 ++
 rtl/dff_segment_for_input.sv | 88 ++++++++
 tb/tb_dff_segment_for_input.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fft_seg_pkg.sv
// Shared FFT segment definitions: lane count, counter width and
// the 3-bit bit-reverse used by the segments and twiddle indexing.
package fft_seg_pkg;

    localparam int NUM_LANES = 8;
    localparam int CNT_WIDTH = 3;

    localparam logic [CNT_WIDTH-1:0] LAST_SLOT = 3'd7;

    function automatic logic [CNT_WIDTH-1:0] bitrev3(
        input logic [CNT_WIDTH-1:0] idx
    );
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/dff_hold_async_low_reset.sv
// DATA_WIDTH register with load enable, pipeline hold and
// asynchronous active-low reset.
module dff_hold_async_low_reset #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en && !hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_segment_for_input.sv
// Serial-to-8-lane input deserializer with double-buffered bank.
// Define DFF_SEG_IN_BITREV_EN for bit-reversed lane order.
module dff_segment_for_input
    import fft_seg_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            hold,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           din,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] Q,
    output logic [CNT_WIDTH-1:0]            frame_cnt
);

    logic                  acc;
    logic                  load;
    logic                  consume;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] samp [NUM_LANES];

    assign frame_cnt = cnt_q;

    // Stall only the frame-completing sample while the bank is still owned
    assign in_ready = !hold &&
        !(cnt_q == LAST_SLOT && out_valid && !out_ready);
    assign acc      = in_valid && in_ready;
    assign load     = acc && (cnt_q == LAST_SLOT);
    assign consume  = out_valid && out_ready && !hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (acc) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES - 1; i++) begin : g_slot
        dff_hold_async_low_reset #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk (clk),
            .rst (rst),
            .hold(hold),
            .en  (acc && (cnt_q == CNT_WIDTH'(i))),
            .d   (din),
            .q   (samp[i])
        );
    end

    assign samp[NUM_LANES-1] = din;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
`ifdef DFF_SEG_IN_BITREV_EN
        localparam int SRC = int'(bitrev3(CNT_WIDTH'(k)));
`else
        localparam int SRC = k;
`endif
        dff_hold_async_low_reset #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .hold(hold),
            .en  (load),
            .d   (samp[SRC]),
            .q   (Q[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_dff_segment_for_input.sv
// Directed self-checking bench for dff_segment_for_input.
module tb_dff_segment_for_input;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          hold;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] din;
    logic          out_valid;
    logic          out_ready;
    logic [255:0]  Q;
    logic [2:0]    frame_cnt;

    int total = 0;
    int bad   = 0;

    dff_segment_for_input #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Q        (Q),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int lane_src(input int k);
`ifdef DFF_SEG_IN_BITREV_EN
        case (k)
            1: return 4;
            3: return 6;
            4: return 1;
            6: return 3;
            default: return k;
        endcase
`else
        return k;
`endif
    endfunction

    function automatic logic [255:0] frame(input int base);
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < 8; k++)
            f[k*32 +: 32] = 32'(base + lane_src(k));
        return f;
    endfunction

    task automatic send(input int v);
        in_valid = 1'b1;
        din      = 32'(v);
        step();
    endtask

    initial begin
        int ir_low;
        int frames;
        int dbl;
        logic prev;
        logic [255:0] q_snap;

        rst = 1'b0; hold = 1'b0; in_valid = 1'b0;
        din = '0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rst_q", Q, '0);
        chk("rst_ov", out_valid, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_ir", in_ready, 1);

        // reset mid-frame
        send(32'hA0); send(32'hA1); send(32'hA2);
        in_valid = 1'b0;
        chk("pre_rst_cnt", frame_cnt, 3);
        rst = 1'b0;
        #1;
        chk("mid_rst_cnt", frame_cnt, 0);
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_q", Q, '0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // natural / bitrev frame
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(32'h10 + i);
        in_valid = 1'b0;
        chk("nat_ov", out_valid, 1);
        chk("nat_q", Q, frame(32'h10));
        chk("nat_cnt", frame_cnt, 0);
        step();
        chk("nat_consumed", out_valid, 0);

        // backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(32'h10 + i);
        in_valid = 1'b1;
        din = 32'h1F;
        chk("bp_cnt", frame_cnt, 7);
        chk("bp_ir_low", in_ready, 0);
        step(); step();
        chk("bp_cnt_hold", frame_cnt, 7);
        chk("bp_q_stable", Q, frame(32'h10));
        chk("bp_ov", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_ir_comb", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_ov_kept", out_valid, 1);
        chk("bp_q_new", Q, frame(32'h18));
        chk("bp_cnt_wrap", frame_cnt, 0);
        step();
        chk("bp_consumed", out_valid, 0);

        // hold at slot 4
        for (int i = 0; i < 4; i++) send(32'h20 + i);
        hold = 1'b1; in_valid = 1'b1; din = 32'h24;
        q_snap = Q;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold_ir", in_ready, 0);
            step();
            chk("hold_cnt", frame_cnt, 4);
        end
        chk("hold_q", Q, q_snap);
        chk("hold_ov", out_valid, 0);
        hold = 1'b0;
        for (int i = 4; i < 8; i++) send(32'h20 + i);
        in_valid = 1'b0;
        chk("hold_ov_after", out_valid, 1);
        chk("hold_q_after", Q, frame(32'h20));
        step();

        // back-to-back 64 samples
        ir_low = 0; frames = 0; dbl = 0; prev = 1'b0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            din = 32'(32'h40 + i);
            #1;
            if (!in_ready) ir_low++;
            step();
            if (out_valid) begin
                if (prev) dbl++;
                chk("b2b_q", Q, frame(32'h40 + 8 * frames));
                frames++;
            end
            prev = out_valid;
        end
        in_valid = 1'b0;
        step();
        chk("b2b_ov_end", out_valid, 0);
        chk("b2b_frames", 256'(frames), 8);
        chk("b2b_ir_low", 256'(ir_low), 0);
        chk("b2b_dbl", 256'(dbl), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
